// File: rtl/sample_differentiator_pkg.sv
// Shared widths, full-scale bounds and FSM encoding for the PID differentiator path.
package sample_differentiator_pkg;

  localparam int unsigned DEF_IN_WIDTH   = 16;
  localparam int unsigned DEF_OUT_WIDTH  = 16;
  localparam int          FULL_SCALE_MAX = 32767;
  localparam int          FULL_SCALE_MIN = -32768;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } diff_state_t;

endpackage

// File: rtl/sample_differentiator_if.sv
// Sample stream in, saturated derivative stream out.
interface sample_differentiator_if
  import sample_differentiator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
);

  logic                        strobe_in;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        strobe_out;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        saturated;
  logic                        primed;

  modport master (
    output strobe_in, in_data,
    input  strobe_out, out_data, saturated, primed
  );

  modport slave (
    input  strobe_in, in_data,
    output strobe_out, out_data, saturated, primed
  );

endinterface

// File: rtl/sample_differentiator_saturator.sv
// Combinational arithmetic left shift followed by clamping to [min_value, max_value].
module signed_left_shift_saturator #(
  parameter int unsigned in_len     = 17,
  parameter int unsigned shift_bits = 4,
  parameter int unsigned out_len    = 16,
  parameter int          max_value  = 32767,
  parameter int          min_value  = -32768
) (
  input  logic signed [in_len-1:0]  din,
  output logic signed [out_len-1:0] dout_c,
  output logic                      sat_c
);

  localparam int unsigned SH_W = in_len + shift_bits;

  logic signed [SH_W-1:0] shifted;
  logic signed [SH_W-1:0] max_ext;
  logic signed [SH_W-1:0] min_ext;

  // Widen before shifting so no magnitude bits are lost, then clamp.
  always_comb begin
    shifted = SH_W'(din) <<< shift_bits;
    max_ext = SH_W'(max_value);
    min_ext = SH_W'(min_value);
    dout_c  = out_len'(shifted);
    sat_c   = 1'b0;
    if (shifted > max_ext) begin
      dout_c = out_len'(max_value);
      sat_c  = 1'b1;
    end else if (shifted < min_ext) begin
      dout_c = out_len'(min_value);
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/sample_differentiator.sv
// D-term differentiator: y = sat((x[n] - x[n-D]) <<< GAIN_SHIFT), one result per input strobe.
module sample_differentiator
  import sample_differentiator_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned DELAY_LOG2 = 2,
  parameter int unsigned GAIN_SHIFT = 4,
  parameter int          MAX_OUT    = FULL_SCALE_MAX,
  parameter int          MIN_OUT    = FULL_SCALE_MIN
) (
  input  logic                    clkIn,
  input  logic                    reset,
  sample_differentiator_if.slave  bus
);

  localparam int unsigned D      = 1 << DELAY_LOG2;
  localparam int unsigned PTR_W  = (DELAY_LOG2 > 0) ? DELAY_LOG2 : 1;
  localparam int unsigned CNT_W  = DELAY_LOG2 + 1;
  localparam int unsigned DIFF_W = IN_WIDTH + 1;

  diff_state_t                 state;
  logic signed [IN_WIDTH-1:0]  dly [D];
  logic        [PTR_W-1:0]     wr_ptr;
  logic        [CNT_W-1:0]     fill_cnt;

  logic                        strobe_out_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        saturated_q;
  logic                        primed_q;

  logic signed [IN_WIDTH-1:0]  old_sample;
  logic signed [DIFF_W-1:0]    diff;
  logic signed [OUT_WIDTH-1:0] sat_data;
  logic                        sat_flag;

  // Oldest sample sits at the write slot; one extra bit makes the difference overflow-free.
  always_comb begin
    old_sample = dly[wr_ptr];
    diff       = DIFF_W'(bus.in_data) - DIFF_W'(old_sample);
  end

  signed_left_shift_saturator #(
    .in_len     (DIFF_W),
    .shift_bits (GAIN_SHIFT),
    .out_len    (OUT_WIDTH),
    .max_value  (MAX_OUT),
    .min_value  (MIN_OUT)
  ) u_shift_sat (
    .din    (diff),
    .dout_c (sat_data),
    .sat_c  (sat_flag)
  );

  // Delay line, fill/run FSM and registered outputs; reset wins over a coincident strobe.
  always_ff @(posedge clkIn) begin
    if (reset) begin
      state        <= FILL;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      strobe_out_q <= 1'b0;
      out_data_q   <= '0;
      saturated_q  <= 1'b0;
      primed_q     <= 1'b0;
      for (int i = 0; i < int'(D); i++) begin
        dly[i] <= '0;
      end
    end else begin
      strobe_out_q <= 1'b0;
      if (bus.strobe_in) begin
        dly[wr_ptr]  <= bus.in_data;
        wr_ptr       <= (DELAY_LOG2 == 0) ? '0 : wr_ptr + PTR_W'(1);
        strobe_out_q <= 1'b1;
        case (state)
          FILL: begin
            out_data_q  <= '0;
            saturated_q <= 1'b0;
            fill_cnt    <= fill_cnt + CNT_W'(1);
            if (fill_cnt == CNT_W'(D - 1)) begin
              state    <= RUN;
              primed_q <= 1'b1;
            end
          end
          RUN: begin
            out_data_q  <= sat_data;
            saturated_q <= sat_flag;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  assign bus.strobe_out = strobe_out_q;
  assign bus.out_data   = out_data_q;
  assign bus.saturated  = saturated_q;
  assign bus.primed     = primed_q;

endmodule
